apb4_cpuif_bridge: RTL and testbench
====================================

// Module: apb4_cpuif_bridge
// PURPOSE
//  APB4 completer to internal register-bus bridge (successor of the fixed-width APB4 slave).
//  - Parametrised address and data widths; out-of-window decode errors; requester stall handling.
//  - Registered wait-state response; optional response timeout.
//  - Sits between the SoC APB fabric and the generated register block (bus_* handshake).
// PARAMETERS
//  PADDR_WIDTH    32   APB paddr width.
//  ADDR_WIDTH     8    register-window byte address width, <= PADDR_WIDTH.
//  DATA_WIDTH     32   data width: 8/16/32/64; STRB_W = DATA_WIDTH/8.
//  TIMEOUT_CYCLES 256  WAIT-state limit, >= 2; used only with APB4_BRIDGE_TIMEOUT_EN.
// PORTS
//  clk              in   1            clock; all logic is on the rising edge.
//  rst              in   1            reset: synchronous, active-high.
//  psel             in   1            APB select.
//  penable          in   1            APB access phase.
//  pwrite           in   1            1 = write.
//  paddr            in   PADDR_WIDTH  byte address.
//  pprot            in   3            protection attributes; pprot[0] = privileged.
//  pwdata           in   DATA_WIDTH   write data.
//  pstrb            in   STRB_W       byte write strobes.
//  pready           out  1            transfer complete (registered).
//  prdata           out  DATA_WIDTH   read data (registered).
//  pslverr          out  1            error response (registered).
//  bus_req          out  1            internal request.
//  bus_req_is_wr    out  1            request is a write.
//  bus_addr         out  ADDR_WIDTH   word-aligned address (low log2(STRB_W) bits = 0).
//  bus_wr_data      out  DATA_WIDTH   write data.
//  bus_wr_biten     out  DATA_WIDTH   bit enables; each pstrb bit replicated x8.
//  bus_req_stall_wr in   1            register block cannot accept a write.
//  bus_req_stall_rd in   1            register block cannot accept a read.
//  bus_rd_ack       in   1            read done.
//  bus_rd_err       in   1            read error, valid with bus_rd_ack.
//  bus_rd_data      in   DATA_WIDTH   read data, valid with bus_rd_ack.
//  bus_wr_ack       in   1            write done.
//  bus_wr_err       in   1            write error, valid with bus_wr_ack.
// BEHAVIOUR
//  - Reset: state=IDLE, pready=0, prdata=0, pslverr=0, bus_req=0, all other bus_* outputs 0.
//  - FSM states: IDLE, REQ, WAIT, RESP, ERR.
//    - IDLE: on psel & !penable (setup phase), capture pwrite, paddr, pwdata and the expanded pstrb.
//      - If paddr[PADDR_WIDTH-1:ADDR_WIDTH] != 0, go to ERR.
//      - Otherwise go to REQ.
//    - REQ: bus_req=1 and fields held stable.
//      - Accepted when the stall for the captured direction is 0; then go to WAIT.
//      - The ack may arrive in the acceptance cycle; if so, go directly to RESP.
//    - WAIT: bus_req=0. On the direction-matching ack, latch data/err and go to RESP.
//    - RESP: one cycle; pready=1, prdata=latched read data (0 for writes), pslverr=latched err. Then IDLE.
//    - ERR: one cycle; pready=1, pslverr=1, prdata=0. No bus_req issued. Then IDLE.
//  - pready, prdata and pslverr are 0 outside RESP/ERR.
//  - Best-case latency: setup cycle T0, REQ at T1 with ack, pready at T2 (one APB wait state).
//  - Acks that do not match the direction, or that arrive in IDLE, REQ (before acceptance), RESP or ERR, are ignored.
//  - bus_rd_ack and bus_wr_ack asserted together: only the one matching the captured direction counts.
//  - psel dropping mid-transfer (protocol violation): the internal transaction still completes and pready is still pulsed.
//  - Back-to-back transfers: the setup phase seen in the cycle after RESP/ERR is captured normally.
//  - rst mid-transfer: return to IDLE next edge and drop bus_req. A late ack is ignored.
// CONFIGURATION
//  - APB4_BRIDGE_TIMEOUT_EN defined:
//    - Counter cleared on entry to REQ; increments every cycle in REQ/WAIT.
//    - Reaching TIMEOUT_CYCLES-1 with no ack forces ERR. bus_req is deasserted on that edge.
//    - A late ack is then ignored.
//  - APB4_BRIDGE_TIMEOUT_EN undefined: no counter; REQ/WAIT wait indefinitely.
// TESTING
//  - Read 0x04, no stall, ack with data 0xA5A5_0001 in the REQ cycle -> pready at T2, prdata=0xA5A5_0001, pslverr=0.
//  - Write 0x08, pwdata=0x1234_5678, pstrb=4'b0101 -> bus_wr_biten=0x00FF_00FF, bus_addr=0x08; wr_ack 3 cycles later -> pready 1 cycle after.
//  - paddr=0x0000_0100 with ADDR_WIDTH=8 -> no bus_req; pready=1 and pslverr=1 at T1.
//  - bus_req_stall_rd=1 for 4 cycles -> bus_req held 5 cycles with stable fields; bus_rd_err=1 -> pslverr=1.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> pready=1 and pslverr=1 after timeout; later ack has no effect.
//  - rst asserted in WAIT -> next cycle all outputs 0 and IDLE; a new read then completes normally.

Source files
------------

// File: rtl/apb4_cpuif_bridge.sv
// -----------------------------------------------------------------------------
// apb4_cpuif_bridge
//   APB4 completer that forwards accesses onto the internal register-bus
//   (bus_* request/ack handshake) of a generated register block.
//   - Setup-phase capture of direction, address, write data and strobes.
//   - Addresses outside the ADDR_WIDTH register window get an immediate
//     error response without touching the register bus.
//   - Requests are held while the register block stalls the direction.
//   - pready/prdata/pslverr are registered; the best case adds one wait state.
//
// Optional feature macro: APB4_BRIDGE_TIMEOUT_EN
//   Defined   : a REQ/WAIT cycle counter forces an error response after
//               TIMEOUT_CYCLES cycles without a matching ack.
//   Undefined : REQ/WAIT wait for the ack indefinitely.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   psel, penable, pwrite    APB control
//   paddr, pprot, pwdata,    APB address / attributes / write data / strobes
//   pstrb
//   pready, prdata, pslverr  APB response (registered)
//   bus_req, bus_req_is_wr,  register-bus request and its fields
//   bus_addr, bus_wr_data,
//   bus_wr_biten
//   bus_req_stall_wr/rd      register block back-pressure per direction
//   bus_rd_ack/err/data      read completion
//   bus_wr_ack/err           write completion
// -----------------------------------------------------------------------------
module apb4_cpuif_bridge #(
  parameter int PADDR_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH-1:0]   bus_wr_biten,
  input  logic                    bus_req_stall_wr,
  input  logic                    bus_req_stall_rd,
  input  logic                    bus_rd_ack,
  input  logic                    bus_rd_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data,
  input  logic                    bus_wr_ack,
  input  logic                    bus_wr_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // Byte-offset bits inside one data word are cleared on the register bus.
  localparam logic [ADDR_WIDTH-1:0] ADDR_LOW_MASK = ADDR_WIDTH'(STRB_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_is_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_biten;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;

  logic                  w_setup;
  logic                  w_out_of_window;
  logic                  w_stall;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_biten;
  logic                  w_unused_ok;

  genvar gi;

  assign w_setup = psel & ~penable;

  // Only the handshake signals of the captured direction are honoured.
  assign w_stall = r_is_wr ? bus_req_stall_wr : bus_req_stall_rd;
  assign w_ack   = r_is_wr ? bus_wr_ack       : bus_rd_ack;
  assign w_err   = r_is_wr ? bus_wr_err       : bus_rd_err;

  // Any set address bit above the register window is a decode error.
  generate
    if (ADDR_WIDTH < PADDR_WIDTH) begin : g_window
      assign w_out_of_window = |paddr[PADDR_WIDTH-1:ADDR_WIDTH];
    end else begin : g_full_window
      assign w_out_of_window = 1'b0;
    end
  endgenerate

  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_biten
      assign w_biten[gi*8 +: 8] = {8{pstrb[gi]}};
    end
  endgenerate

`ifdef APB4_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts cycles spent in REQ/WAIT; REQ is only entered from IDLE, so
  // holding the counter at zero elsewhere clears it on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_tmo_cnt == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Protection attributes are not used for access control here.
  assign w_unused_ok = ^{pprot, (TIMEOUT_CYCLES > 0)};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_state_next = w_out_of_window ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        // An ack in the acceptance cycle skips WAIT; an ack while the
        // request is still stalled does not count.
        if (!w_stall && w_ack) begin
          w_state_next = S_RESP;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end else if (!w_stall) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          w_state_next = S_RESP;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request fields and registered APB response. The response flops are
  // loaded on the edge entering RESP/ERR, so they double as the ack latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_biten   <= '0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_setup) begin
        r_is_wr <= pwrite;
        r_addr  <= paddr[ADDR_WIDTH-1:0] & ~ADDR_LOW_MASK;
        r_wdata <= pwdata;
        r_biten <= w_biten;
      end

      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      if (w_state_next == S_RESP) begin
        r_pready  <= 1'b1;
        r_prdata  <= r_is_wr ? '0 : bus_rd_data;
        r_pslverr <= w_err;
      end else if (w_state_next == S_ERR) begin
        r_pready  <= 1'b1;
        r_pslverr <= 1'b1;
      end
    end
  end

  assign pready        = r_pready;
  assign prdata        = r_prdata;
  assign pslverr       = r_pslverr;
  assign bus_req       = (r_state == S_REQ);
  assign bus_req_is_wr = r_is_wr;
  assign bus_addr      = r_addr;
  assign bus_wr_data   = r_wdata;
  assign bus_wr_biten  = r_biten;

endmodule

// File: tb/tb_apb4_cpuif_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb4_cpuif_bridge
//   Directed transfers against apb4_cpuif_bridge (32/8/32, timeout 16 when the
//   APB4_BRIDGE_TIMEOUT_EN build is used). Each transfer is described by a
//   small record; a timeline model turns it into per-cycle expected outputs,
//   and a negedge process compares every output on every cycle.
// -----------------------------------------------------------------------------
module tb_apb4_cpuif_bridge;

  localparam int TMO   = 16;
  localparam int N     = 512;
  localparam int NEVER = 1 << 30;

  typedef struct packed {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          stall;      // stall cycles before acceptance
    int          ack_dly;    // ack cycles after acceptance, -1 = no ack
    bit          err;
    logic [31:0] rdata;
    int          rst_at;     // reset this many cycles after setup, -1 = none
    bit          drop_psel;
    bit          dual_ack;
    bit          wrong_ack;
    bit          early_ack;
    bit          late_ack;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        bus_req, bus_req_is_wr;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wr_data, bus_wr_biten;
  logic        bus_req_stall_wr, bus_req_stall_rd;
  logic        bus_rd_ack, bus_rd_err;
  logic [31:0] bus_rd_data;
  logic        bus_wr_ack, bus_wr_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  // Model expectations per cycle
  logic        exp_pready [N];
  logic        exp_pslverr[N];
  logic [31:0] exp_prdata [N];
  logic        exp_req    [N];
  logic        exp_wr     [N];
  logic [7:0]  exp_addr   [N];
  logic [31:0] exp_wdata  [N];
  logic [31:0] exp_biten  [N];

  // DUT outputs seen per cycle, for literal spot checks
  logic        got_pready [N];
  logic        got_pslverr[N];
  logic [31:0] got_prdata [N];
  logic        got_req    [N];
  logic        got_wr     [N];
  logic [7:0]  got_addr   [N];
  logic [31:0] got_wdata  [N];
  logic [31:0] got_biten  [N];

  apb4_cpuif_bridge #(
    .PADDR_WIDTH   (32),
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pprot           (pprot),
    .pwdata          (pwdata),
    .pstrb           (pstrb),
    .pready          (pready),
    .prdata          (prdata),
    .pslverr         (pslverr),
    .bus_req         (bus_req),
    .bus_req_is_wr   (bus_req_is_wr),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_wr_biten    (bus_wr_biten),
    .bus_req_stall_wr(bus_req_stall_wr),
    .bus_req_stall_rd(bus_req_stall_rd),
    .bus_rd_ack      (bus_rd_ack),
    .bus_rd_err      (bus_rd_err),
    .bus_rd_data     (bus_rd_data),
    .bus_wr_ack      (bus_wr_ack),
    .bus_wr_err      (bus_wr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      got_pready[cyc]  = pready;
      got_pslverr[cyc] = pslverr;
      got_prdata[cyc]  = prdata;
      got_req[cyc]     = bus_req;
      got_wr[cyc]      = bus_req_is_wr;
      got_addr[cyc]    = bus_addr;
      got_wdata[cyc]   = bus_wr_data;
      got_biten[cyc]   = bus_wr_biten;
      chk("pready",  cyc, 64'(pready),  64'(exp_pready[cyc]));
      chk("pslverr", cyc, 64'(pslverr), 64'(exp_pslverr[cyc]));
      chk("prdata",  cyc, 64'(prdata),  64'(exp_prdata[cyc]));
      chk("bus_req", cyc, 64'(bus_req), 64'(exp_req[cyc]));
      if (exp_req[cyc]) begin
        chk("bus_req_is_wr", cyc, 64'(bus_req_is_wr), 64'(exp_wr[cyc]));
        chk("bus_addr",      cyc, 64'(bus_addr),      64'(exp_addr[cyc]));
        chk("bus_wr_data",   cyc, 64'(bus_wr_data),   64'(exp_wdata[cyc]));
        chk("bus_wr_biten",  cyc, 64'(bus_wr_biten),  64'(exp_biten[cyc]));
      end
    end
  end

  // Timeline model: what the APB and register-bus outputs must show for a
  // transfer whose setup phase is in cycle t0. Returns the response cycle.
  function automatic void model_fill(input txn_t t, input int t0, output int tr);
    int          t1, ta, tk, last_req, cut;
    logic        resp_err;
    logic [31:0] resp_data;
    logic [31:0] biten;
    t1  = t0 + 1;
    cut = (t.rst_at >= 0) ? t0 + t.rst_at : NEVER;
    for (int b = 0; b < 4; b++) biten[b*8 +: 8] = {8{t.strb[b]}};
    if (t.addr[31:8] != 24'd0) begin
      tr        = t1;
      last_req  = t0;
      resp_err  = 1'b1;
      resp_data = 32'd0;
    end else begin
      ta        = t1 + t.stall;
      tk        = (t.ack_dly < 0) ? NEVER : ta + t.ack_dly;
      last_req  = ta;
      tr        = tk + 1;
      resp_err  = t.err;
      resp_data = t.wr ? 32'd0 : t.rdata;
`ifdef APB4_BRIDGE_TIMEOUT_EN
      if (tk > t1 + TMO - 1) begin
        last_req  = (ta < t1 + TMO - 1) ? ta : t1 + TMO - 1;
        tr        = t1 + TMO;
        resp_err  = 1'b1;
        resp_data = 32'd0;
      end
`endif
    end
    for (int c = t1; c <= last_req; c++) begin
      if (c <= cut && c < N) begin
        exp_req[c]   = 1'b1;
        exp_wr[c]    = t.wr;
        exp_addr[c]  = t.addr[7:0] & 8'hFC;
        exp_wdata[c] = t.wdata;
        exp_biten[c] = biten;
      end
    end
    if (tr <= cut && tr < N) begin
      exp_pready[tr]  = 1'b1;
      exp_pslverr[tr] = resp_err;
      exp_prdata[tr]  = resp_data;
    end
  endfunction

  task automatic drive_idle();
    psel = 1'b0; penable = 1'b0;
    bus_req_stall_wr = 1'b0; bus_req_stall_rd = 1'b0;
    bus_rd_ack = 1'b0; bus_rd_err = 1'b0; bus_rd_data = 32'd0;
    bus_wr_ack = 1'b0; bus_wr_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_dir(input bit wr, input bit e, input logic [31:0] d);
    if (wr) begin
      bus_wr_ack = 1'b1; bus_wr_err = e;
    end else begin
      bus_rd_ack = 1'b1; bus_rd_err = e; bus_rd_data = d;
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input int stall, input int ack_dly, input bit err,
                              input logic [31:0] rdata);
    txn_t t;
    t = '0;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.stall = stall; t.ack_dly = ack_dly; t.err = err; t.rdata = rdata;
    t.rst_at = -1;
    return t;
  endfunction

  // Drives one transfer from the current cycle on; the schedule comes from
  // the record, never from watching DUT outputs.
  task automatic run_txn(input txn_t t, input int id, output int t0, output int tr);
    int ta, tk, cut, last;
    t0 = cyc;
    model_fill(t, t0, tr);
    ta   = t0 + 1 + t.stall;
    tk   = (t.ack_dly < 0) ? NEVER : ta + t.ack_dly;
    cut  = (t.rst_at >= 0) ? t0 + t.rst_at : tr;
    last = (t.rst_at >= 0) ? t0 + t.rst_at + 2 : (t.late_ack ? tr + 2 : tr);
    $display("txn %0d: %s addr=%h setup_cycle=%0d resp_cycle=%0d",
             id, t.wr ? "WR" : "RD", t.addr, t0, tr);
    for (int c = t0; c <= last; c++) begin
      drive_idle();
      rst = (t.rst_at >= 0 && c == t0 + t.rst_at);
      if (c <= cut) begin
        psel    = !(t.drop_psel && c >= t0 + 2);
        penable = (c > t0);
        pwrite  = t.wr;
        paddr   = t.addr;
        pwdata  = t.wdata;
        pstrb   = t.strb;
        if (c > t0 && c < ta) begin
          if (t.wr) bus_req_stall_wr = 1'b1;
          else      bus_req_stall_rd = 1'b1;
        end
        if (t.early_ack && t.stall > 0 && c == t0 + 1)
          ack_dir(t.wr, 1'b0, 32'h5555_5555);
        if (t.wrong_ack && c == tk - 1 && c > ta)
          ack_dir(!t.wr, 1'b1, 32'h6666_6666);
        if (c == tk) begin
          if (t.dual_ack) ack_dir(!t.wr, 1'b1, 32'h7777_7777);
          ack_dir(t.wr, t.err, t.rdata);
        end
      end
      if (t.late_ack && c == last)
        ack_dir(t.wr, 1'b1, 32'hFFFF_FFFF);
      step();
    end
    drive_idle();
    rst = 1'b0;
  endtask

  initial begin : stim
    txn_t t;
    int   t0, tr;
    for (int i = 0; i < N; i++) begin
      exp_pready[i] = 1'b0; exp_pslverr[i] = 1'b0; exp_prdata[i] = 32'd0;
      exp_req[i] = 1'b0; exp_wr[i] = 1'b0; exp_addr[i] = 8'd0;
      exp_wdata[i] = 32'd0; exp_biten[i] = 32'd0;
    end
    drive_idle();
    rst = 1'b1; pwrite = 1'b0; paddr = 32'd0; pprot = 3'd0;
    pwdata = 32'd0; pstrb = 4'd0;
    step();
    chk_on = 1'b1;
    step(); step();
    rst = 1'b0;
    // Reset state
    chk("rst_pready",  2, 64'(got_pready[2]),  64'd0);
    chk("rst_prdata",  2, 64'(got_prdata[2]),  64'd0);
    chk("rst_pslverr", 2, 64'(got_pslverr[2]), 64'd0);
    chk("rst_bus_req", 2, 64'(got_req[2]),     64'd0);
    chk("rst_is_wr",   2, 64'(got_wr[2]),      64'd0);
    chk("rst_addr",    2, 64'(got_addr[2]),    64'd0);
    chk("rst_wdata",   2, 64'(got_wdata[2]),   64'd0);
    chk("rst_biten",   2, 64'(got_biten[2]),   64'd0);

    // Acks while idle must do nothing
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      bus_rd_ack = 1'b1; bus_rd_err = 1'b1; bus_rd_data = 32'hDEAD_0000;
      bus_wr_ack = 1'b1; bus_wr_err = 1'b1;
      step();
    end
    drive_idle();
    step();

    // 1: read 0x04, ack in the REQ cycle
    t = mk(1'b0, 32'h04, 32'd0, 4'hF, 0, 0, 1'b0, 32'hA5A5_0001);
    run_txn(t, 1, t0, tr);
    chk("t1_pready_T2", t0 + 2, 64'(got_pready[t0+2]), 64'd1);
    chk("t1_prdata_T2", t0 + 2, 64'(got_prdata[t0+2]), 64'hA5A5_0001);
    step();

    // 2: write 0x08, strobes 0101, ack three cycles after acceptance
    t = mk(1'b1, 32'h08, 32'h1234_5678, 4'b0101, 0, 3, 1'b0, 32'd0);
    run_txn(t, 2, t0, tr);
    chk("t2_biten", t0 + 1, 64'(got_biten[t0+1]), 64'h00FF_00FF);
    chk("t2_addr",  t0 + 1, 64'(got_addr[t0+1]),  64'h08);
    chk("t2_pready", t0 + 5, 64'(got_pready[t0+5]), 64'd1);
    step();

    // 3: out-of-window address
    t = mk(1'b0, 32'h0000_0100, 32'd0, 4'hF, 0, 0, 1'b0, 32'h1111_1111);
    run_txn(t, 3, t0, tr);
    chk("t3_pready_T1",  t0 + 1, 64'(got_pready[t0+1]),  64'd1);
    chk("t3_pslverr_T1", t0 + 1, 64'(got_pslverr[t0+1]), 64'd1);
    chk("t3_no_req",     t0 + 1, 64'(got_req[t0+1]),     64'd0);
    step();

    // 4: read stalled 4 cycles (early ack ignored), error response
    t = mk(1'b0, 32'h10, 32'd0, 4'hF, 4, 0, 1'b1, 32'hDEAD_BEEF);
    t.early_ack = 1'b1;
    run_txn(t, 4, t0, tr);
    chk("t4_req_last",  t0 + 5, 64'(got_req[t0+5]),     64'd1);
    chk("t4_req_drop",  t0 + 6, 64'(got_req[t0+6]),     64'd0);
    chk("t4_pslverr",   t0 + 6, 64'(got_pslverr[t0+6]), 64'd1);
    step();

    // 5: unaligned write, wrong-direction ack in WAIT, both acks together
    t = mk(1'b1, 32'h0E, 32'hCAFE_BABE, 4'b1100, 0, 2, 1'b0, 32'd0);
    t.wrong_ack = 1'b1;
    t.dual_ack  = 1'b1;
    run_txn(t, 5, t0, tr);
    chk("t5_addr_aligned", t0 + 1, 64'(got_addr[t0+1]), 64'h0C);
    // 6: back-to-back read with psel dropped mid-transfer
    t = mk(1'b0, 32'hFC, 32'd0, 4'hF, 0, 1, 1'b0, 32'h0BAD_F00D);
    t.drop_psel = 1'b1;
    run_txn(t, 6, t0, tr);
    chk("t6_prdata", t0 + 3, 64'(got_prdata[t0+3]), 64'h0BAD_F00D);
    step();

    // 7: reset while in WAIT, late ack ignored, then a normal read
    t = mk(1'b0, 32'h20, 32'd0, 4'hF, 0, 5, 1'b0, 32'h2222_2222);
    t.rst_at   = 2;
    t.late_ack = 1'b1;
    run_txn(t, 7, t0, tr);
    chk("t7_rst_pready", t0 + 3, 64'(got_pready[t0+3]), 64'd0);
    chk("t7_rst_req",    t0 + 3, 64'(got_req[t0+3]),    64'd0);
    chk("t7_rst_addr",   t0 + 3, 64'(got_addr[t0+3]),   64'd0);
    t = mk(1'b0, 32'h24, 32'd0, 4'hF, 0, 0, 1'b0, 32'h1234_5678);
    run_txn(t, 8, t0, tr);
    chk("t8_prdata", t0 + 2, 64'(got_prdata[t0+2]), 64'h1234_5678);
    step();

`ifdef APB4_BRIDGE_TIMEOUT_EN
    // 9: no ack at all; timeout error then a late ack
    t = mk(1'b0, 32'h30, 32'd0, 4'hF, 0, -1, 1'b0, 32'd0);
    t.late_ack = 1'b1;
    run_txn(t, 9, t0, tr);
    chk("t9_tmo_pready",  t0 + 17, 64'(got_pready[t0+17]),  64'd1);
    chk("t9_tmo_pslverr", t0 + 17, 64'(got_pslverr[t0+17]), 64'd1);
    step();
`endif

    step(); step();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
